// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode-stage encodings, field positions and the execute bundle type.
package cpu_pkg;

  localparam int XLEN_P = 32;
  localparam int REG_AW = 4;

  localparam int OPC_LSB = 28;
  localparam int FN_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;
  localparam int IMM_W   = 16;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_F   = 6'h10;
  localparam logic [5:0] OP_GTZ = 6'h1F;
  localparam logic [5:0] OP_JAL = 6'h20;

  localparam logic [1:0] GRP_ALU = 2'b00;
  localparam logic [1:0] GRP_CMP = 2'b01;

  localparam logic [3:0] FN_MVHI = 4'hB;

  typedef enum logic [3:0] {
    CLS_ALUR  = 4'h0,
    CLS_CMPR  = 4'h2,
    CLS_SW    = 4'h5,
    CLS_BCOND = 4'h6,
    CLS_ALUI  = 4'h8,
    CLS_LW    = 4'h9,
    CLS_CMPI  = 4'hA,
    CLS_JAL   = 4'hB
  } opc_e;

  typedef struct packed {
    logic [5:0]        opsel;
    logic [XLEN_P-1:0] a;
    logic [XLEN_P-1:0] b;
    logic [XLEN_P-1:0] store_data;
    logic [XLEN_P-1:0] pc;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              link;
    logic              illegal;
  } exec_bundle_t;

  function automatic logic [XLEN_P-1:0] sext16(input logic [IMM_W-1:0] imm);
    return {{(XLEN_P-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational instruction word to class, control flags,
// ALU opsel and source-register usage.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  rd_o,
  output logic [3:0]  rs1_o,
  output logic [3:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic [5:0]  opsel_o,
  output logic        use_rs1_o,
  output logic        use_rs2_o,
  output logic        b_imm_o,
  output logic        wr_en_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        branch_o,
  output logic        link_o,
  output logic        illegal_o
);

  opc_e       cls;
  logic [3:0] fn;

  assign cls   = opc_e'(instr_i[OPC_LSB +: 4]);
  assign fn    = instr_i[FN_LSB +: 4];
  assign rd_o  = instr_i[RD_LSB +: 4];
  assign rs1_o = instr_i[RS1_LSB +: 4];
  assign rs2_o = instr_i[RS2_LSB +: 4];
  assign imm_o = sext16(instr_i[IMM_W-1:0]);

  always_comb begin
    opsel_o   = OP_F;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    b_imm_o   = 1'b1;
    wr_en_o   = 1'b0;
    mem_rd_o  = 1'b0;
    mem_wr_o  = 1'b0;
    branch_o  = 1'b0;
    link_o    = 1'b0;
    illegal_o = 1'b0;
    case (cls)
      CLS_ALUR: begin
        opsel_o   = {GRP_ALU, fn};
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        b_imm_o   = 1'b0;
        wr_en_o   = 1'b1;
      end
      // MVHI builds its result from the immediate alone, so rs1 is not a true source.
      CLS_ALUI: begin
        opsel_o   = {GRP_ALU, fn};
        use_rs1_o = (fn != FN_MVHI);
        wr_en_o   = 1'b1;
      end
      CLS_CMPR: begin
        opsel_o   = {GRP_CMP, fn};
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        b_imm_o   = 1'b0;
        wr_en_o   = 1'b1;
      end
      CLS_CMPI: begin
        opsel_o   = {GRP_CMP, fn};
        use_rs1_o = 1'b1;
        wr_en_o   = 1'b1;
      end
      CLS_BCOND: begin
        opsel_o   = {GRP_CMP, fn};
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        b_imm_o   = 1'b0;
        branch_o  = 1'b1;
      end
      CLS_JAL: begin
        opsel_o   = OP_JAL;
        use_rs1_o = 1'b1;
        link_o    = 1'b1;
        wr_en_o   = 1'b1;
      end
      CLS_LW: begin
        opsel_o   = OP_ADD;
        use_rs1_o = 1'b1;
        mem_rd_o  = 1'b1;
        wr_en_o   = 1'b1;
      end
      CLS_SW: begin
        opsel_o   = OP_ADD;
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        mem_wr_o  = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes one instruction per handshake into a registered execute bundle.
// Define DECODE_SCOREBOARD_EN to enable the per-register RAW scoreboard and issue stall.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic [$clog2(NREGS)-1:0] rf_ra1,
  output logic [$clog2(NREGS)-1:0] rf_ra2,
  input  logic [XLEN-1:0]          rf_rd1,
  input  logic [XLEN-1:0]          rf_rd2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_opsel,
  output logic [XLEN-1:0]          out_a,
  output logic [XLEN-1:0]          out_b,
  output logic [XLEN-1:0]          out_store_data,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic                     out_wr_en,
  output logic                     out_mem_rd,
  output logic                     out_mem_wr,
  output logic                     out_branch,
  output logic                     out_link,
  output logic                     out_illegal,
  output logic [31:0]              out_pc,
  input  logic                     flush,
  input  logic                     wb_valid,
  input  logic [$clog2(NREGS)-1:0] wb_rd
);

  logic [3:0]   dec_rd, dec_rs1, dec_rs2;
  logic [31:0]  dec_imm;
  logic [5:0]   dec_opsel;
  logic         dec_use_rs1, dec_use_rs2, dec_b_imm;
  logic         dec_wr_en, dec_mem_rd, dec_mem_wr, dec_branch, dec_link, dec_illegal;

  exec_bundle_t bundle_d, out_q;
  logic         out_valid_q;
  logic         hazard, accept, transfer;

  instr_decoder u_dec (
    .instr_i   (in_instr),
    .rd_o      (dec_rd),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .imm_o     (dec_imm),
    .opsel_o   (dec_opsel),
    .use_rs1_o (dec_use_rs1),
    .use_rs2_o (dec_use_rs2),
    .b_imm_o   (dec_b_imm),
    .wr_en_o   (dec_wr_en),
    .mem_rd_o  (dec_mem_rd),
    .mem_wr_o  (dec_mem_wr),
    .branch_o  (dec_branch),
    .link_o    (dec_link),
    .illegal_o (dec_illegal)
  );

  assign rf_ra1 = dec_rs1;
  assign rf_ra2 = dec_rs2;

  // Branches reuse the store-data lane to carry their sign-extended offset.
  always_comb begin
    bundle_d            = '0;
    bundle_d.opsel      = dec_opsel;
    bundle_d.a          = rf_rd1;
    bundle_d.b          = dec_b_imm ? dec_imm : rf_rd2;
    bundle_d.store_data = dec_branch ? dec_imm : rf_rd2;
    bundle_d.pc         = in_pc;
    bundle_d.rd         = dec_rd;
    bundle_d.wr_en      = dec_wr_en;
    bundle_d.mem_rd     = dec_mem_rd;
    bundle_d.mem_wr     = dec_mem_wr;
    bundle_d.branch     = dec_branch;
    bundle_d.link       = dec_link;
    bundle_d.illegal    = dec_illegal;
  end

  assign transfer = out_valid_q & out_ready;

`ifdef DECODE_SCOREBOARD_EN
  logic [NREGS-1:0] pending_q, pending_d;
  logic             held_wr;
  logic             haz_rs1, haz_rs2;

  // A bundle still sitting in the output register has not yet marked its rd pending.
  assign held_wr = out_valid_q & out_q.wr_en;
  assign haz_rs1 = dec_use_rs1 & (pending_q[dec_rs1] | (held_wr & (out_q.rd == dec_rs1)));
  assign haz_rs2 = dec_use_rs2 & (pending_q[dec_rs2] | (held_wr & (out_q.rd == dec_rs2)));
  assign hazard  = haz_rs1 | haz_rs2;

  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_rd] = 1'b0;
    if (transfer & out_q.wr_en & ~flush) pending_d[out_q.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{wb_valid, wb_rd, dec_use_rs1, dec_use_rs2};
  assign hazard    = 1'b0;
`endif

  assign in_ready = flush | (~hazard & (~out_valid_q | out_ready));
  assign accept   = in_valid & in_ready;

  // Flush wins over an accept offered in the same cycle: that instruction is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= bundle_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_opsel      = out_q.opsel;
  assign out_a          = out_q.a;
  assign out_b          = out_q.b;
  assign out_store_data = out_q.store_data;
  assign out_rd         = out_q.rd;
  assign out_wr_en      = out_q.wr_en;
  assign out_mem_rd     = out_q.mem_rd;
  assign out_mem_wr     = out_q.mem_wr;
  assign out_branch     = out_q.branch;
  assign out_link       = out_q.link;
  assign out_illegal    = out_q.illegal;
  assign out_pc         = out_q.pc;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage: accepts one fetched 32-bit instruction word plus PC per handshake, reads two source registers, and produces a registered execute bundle. The bundle carries the 6-bit ALU opsel, A/B operands and writeback/memory/branch control, and feeds the ALU in the execute stage. A per-register scoreboard stalls issue on read-after-write hazards until the writeback stage retires the producing instruction.

## Interface
Parameters:
- NREGS, 16, architectural registers; index width is clog2(NREGS) = 4.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of in_instr.
- rf_ra1, rf_ra2  out  4  register-file read addresses; combinational from in_instr[19:16] and in_instr[15:12].
- rf_rd1, rf_rd2  in  32  register-file read data, combinational and same-cycle.
- out_valid  out  1  execute bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_opsel  out  6  ALU opsel.
- out_a, out_b  out  32  ALU operands.
- out_store_data  out  32  rs2 value, for stores.
- out_rd  out  4  destination register.
- out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_link, out_illegal  out  1 each  control flags.
- out_pc  out  32  PC of the bundle.
- flush  in  1  squash the decode output register and any in-flight accept.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  4  register retired.

## Operation
- Instruction fields: [31:28] opc, [27:24] fn, [23:20] rd, [19:16] rs1, [15:12] rs2, [15:0] imm16. sext(imm16) is used for B.
- Opcode classes:
  - 0x0 ALUR: opsel {00,fn}; A=rs1, B=rs2; writes rd.
  - 0x8 ALUI: opsel {00,fn}; A=rs1, B=sext(imm); writes rd. fn=0xB is MVHI.
  - 0x2 CMPR: opsel {01,fn}; A=rs1, B=rs2; writes rd.
  - 0xA CMPI: opsel {01,fn}; A=rs1, B=sext(imm); writes rd.
  - 0x6 BCOND: opsel {01,fn}; A=rs1, B=rs2; out_branch=1; no write. out_store_data carries sext(imm) as the branch offset.
  - 0xB JAL: opsel 0x20; A=rs1, B=sext(imm); out_link=1; writes rd.
  - 0x9 LW: opsel 0x00; A=rs1, B=sext(imm); out_mem_rd=1; writes rd.
  - 0x5 SW: opsel 0x00; A=rs1, B=sext(imm); out_mem_wr=1; store data=rs2; no write.
  - Any other opc: out_illegal=1. All write, memory and branch flags are 0; opsel=0x10 (F).
- Source usage:
  - rs2 is used only by ALUR, CMPR, BCOND and SW.
  - rs1 is used by every legal class except ALUI with fn=0xB.
- Scoreboard: pending[NREGS].
  - A bit is set when a write-enabled bundle transfers (out_valid & out_ready).
  - A bit is cleared on wb_valid for wb_rd.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: a used source is pending, or it equals out_rd of a valid write-enabled bundle still held in the output register.
- in_ready = ~hazard & (~out_valid | out_ready), or 1 while flush=1.

## Timing
- Reset: out_valid=0, pending=0, and every out_* data/flag field is 0.
- Latency: one cycle from accept to out_valid.
- Output fields hold stable while out_valid & ~out_ready.
- A clear by wb_valid takes effect the following cycle. The hazard check uses registered pending only, so there is one bubble after writeback.
- flush: out_valid goes to 0 at the next edge. The instruction offered that cycle is consumed and discarded. The scoreboard is not modified by the flushed bundle.
- flush with wb_valid in the same cycle: the clear is still applied.
- Accept and transfer in the same cycle: the output register reloads with no bubble.
- rst_n assertion mid-stall drops everything immediately.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard and hazard stall as above.
- Not defined: no pending register exists and hazard is tied to 0; software schedules NOPs. wb_valid and wb_rd are ignored.

## Structure
- Shared package cpu_pkg holds:
  - opsel constants: ADD 0x00 … GTZ 0x1F, JAL 0x20.
  - opcode class constants.
  - field bit positions.
  - a packed struct for the execute bundle.
- Sub-module instr_decoder is purely combinational: instruction word to class, flags, opsel and source-used bits. decode_stage adds operand muxing, the scoreboard, the handshake and the output register.

## Test plan
- ALUR ADD r3=r1+r2 (rf 5, 7): opsel 0x00, A=5, B=7, out_rd=3, wr_en=1, one cycle after accept.
- ALUI imm 0xFFFC: B=0xFFFFFFFC. MVHI fn=0xB: rs1 unused, so no stall even if r1 is pending.
- Back-to-back ADD r3 then SUB r4=r3-r1: in_ready stays 0 until wb_valid(r3) plus one cycle; SUB issues with the fresh r3.
- out_ready held 0 for 3 cycles: out_* is stable and in_ready=0; release → next bundle the following cycle.
- BCOND at output with flush=1: out_valid=0 next cycle, the offered instruction is dropped, pending is unchanged.
- opc 0xF: out_illegal=1, opsel 0x10, wr_en=0; with macro off, RAW pair issues without stall.
